// File: rtl/ws2812b_pkg.sv
// Shared types, colour constants and cycle-count helpers for the WS2812B strip transmitter.
package ws2812b_pkg;

    typedef enum logic [2:0] {
        S_LATCH,
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW
    } state_t;

    typedef logic [23:0] grb_t;

    localparam grb_t BLACK = 24'h000000;
    localparam grb_t RED   = 24'h00FF00;
    localparam grb_t GREEN = 24'hFF0000;
    localparam grb_t BLUE  = 24'h0000FF;
    localparam grb_t WHITE = 24'hFFFFFF;

    function automatic int unsigned cyc_from_ns(input int unsigned clk_hz, input int unsigned ns);
        return (clk_hz / 1_000_000) * ns / 1000;
    endfunction

    function automatic int unsigned cyc_from_us(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ws2812b_strip_tx_bit_tx.sv
// ws2812b_bit_tx: serialises one 24-bit GRB word MSB first with WS2812B high/low timing.
module ws2812b_bit_tx
    import ws2812b_pkg::*;
#(
    parameter int unsigned T0H  = 40,
    parameter int unsigned T1H  = 80,
    parameter int unsigned TBIT = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  grb_t word_i,
    output logic data_o,
    output logic done_c_o
);

    localparam int unsigned CW = $clog2(TBIT + 1);
    localparam int unsigned BW = 5;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    grb_t          shreg_q, shreg_d;
    logic          data_q, data_d;
    logic [CW-1:0] hi_len, lo_len;

    assign hi_len = shreg_q[23] ? CW'(T1H) : CW'(T0H);
    assign lo_len = CW'(TBIT) - hi_len;
    assign data_o = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
        end
    end

    // data_d follows the state being entered so the line is high exactly during S_HIGH
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        done_c_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shreg_d = word_i;
                    bit_d   = BW'(23);
                    cnt_d   = '0;
                    data_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == hi_len - CW'(1)) begin
                    cnt_d   = '0;
                    data_d  = 1'b0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == lo_len - CW'(1)) begin
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        shreg_d = {shreg_q[22:0], 1'b0};
                        bit_d   = bit_q - BW'(1);
                        data_d  = 1'b1;
                        state_d = S_HIGH;
                    end else begin
                        done_c_o = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/ws2812b_strip_tx.sv
// Frame-buffered WS2812B strip transmitter: per-LED colour buffer, dirty tracking,
// full-strip resend with latch gap whenever the buffer has been written.
module ws2812b_strip_tx
    import ws2812b_pkg::*;
#(
    parameter int unsigned NB_LEDS = 15,
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned T0H_NS  = 400,
    parameter int unsigned T1H_NS  = 800,
    parameter int unsigned TBIT_NS = 1250,
    parameter int unsigned TRST_US = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] color,
    input  logic [31:0] nb_led,
    input  logic        write,
    output logic        data,
    output logic        busy
);

    localparam int unsigned T0H  = cyc_from_ns(CLK_HZ, T0H_NS);
    localparam int unsigned T1H  = cyc_from_ns(CLK_HZ, T1H_NS);
    localparam int unsigned TBIT = cyc_from_ns(CLK_HZ, TBIT_NS);
    localparam int unsigned TRST = cyc_from_us(CLK_HZ, TRST_US);
    localparam int unsigned RW   = $clog2(TRST + 1);
    localparam int unsigned LW   = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;

    grb_t          led_buf_q [NB_LEDS];
    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] led_q, led_d;
    logic          dirty_q, dirty_d;
    logic          busy_q, busy_d;
    logic          start_c, tx_done_c, tx_data;
    logic          wr_ok;
    logic [LW-1:0] wr_idx;

    assign wr_ok  = write && (nb_led < 32'(NB_LEDS));
    assign wr_idx = nb_led[LW-1:0];
    assign data   = tx_data;
    assign busy   = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NB_LEDS); i++) led_buf_q[i] <= BLACK;
        end else if (wr_ok) begin
            led_buf_q[wr_idx] <= color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LATCH;
            cnt_q   <= '0;
            led_q   <= '0;
            dirty_q <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dirty_q <= dirty_d;
            busy_q  <= busy_d;
        end
    end

    // S_HIGH here means "word in flight": the serialiser owns the high/low phases
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        dirty_d = dirty_q;
        start_c = 1'b0;
        unique case (state_q)
            S_LATCH: begin
                if (cnt_q == RW'(TRST - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            S_IDLE: begin
                if (dirty_q) begin
                    dirty_d = 1'b0;
                    led_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                start_c = 1'b1;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (tx_done_c) begin
                    if (led_q == LW'(NB_LEDS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_LATCH;
                    end else begin
                        led_d   = led_q + LW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_LATCH;
        endcase
        // a concurrent write beats the idle-state clear so the next frame still follows
        if (wr_ok) dirty_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    ws2812b_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_c),
        .word_i   (led_buf_q[led_q]),
        .data_o   (tx_data),
        .done_c_o (tx_done_c)
    );

endmodule

// File: tb/tb_ws2812b_strip_tx.sv
// Directed bench for ws2812b_strip_tx: decodes the data line by high-pulse width and
// checks frame contents, write latency, gaps, out-of-range writes and mid-frame reset.
module tb_ws2812b_strip_tx;
    import ws2812b_pkg::*;

    // 10 MHz keeps frames short: T0H=4, T1H=8, TBIT=12 (12.5 truncated), TRST=300 with TRST_US=30
    localparam int NB   = 15;
    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int TBIT = 12;
    localparam int TRST = 300;
    localparam int BITS = NB * 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [23:0] color;
    logic [31:0] nb_led;
    logic        data;
    logic        busy;

    int   passes = 0;
    int   checks = 0;
    int   fails  = 0;
    bit   dead   = 1'b0;
    grb_t got   [NB];
    grb_t exp_f [NB];
    int   first_lo, last_hi, bad_t, lo_idle, cnt;

    ws2812b_strip_tx #(
        .NB_LEDS (NB),
        .CLK_HZ  (10_000_000),
        .T0H_NS  (400),
        .T1H_NS  (800),
        .TBIT_NS (1250),
        .TRST_US (30)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .color  (color),
        .nb_led (nb_led),
        .write  (write),
        .data   (data),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_write(input logic [31:0] idx, input grb_t col);
        nb_led = idx;
        color  = col;
        write  = 1'b1;
        @(negedge clk);
        write  = 1'b0;
    endtask

    // lo = low samples before the rise; hi = high samples (consumes the first low sample after)
    task automatic rx_bit(input bit inj, output int lo, output int hi);
        lo = 0;
        hi = 0;
        if (dead) return;
        forever begin
            @(negedge clk);
            if (data === 1'b1) break;
            lo++;
            if (lo > 2 * TRST) begin
                dead = 1'b1;
                chk("rise_in_budget", 32'(data), 32'(1));
                return;
            end
        end
        if (inj) begin
            nb_led = 32'd0;
            color  = WHITE;
            write  = 1'b1;
        end
        hi = 1;
        forever begin
            @(negedge clk);
            if (inj) write = 1'b0;
            if (data !== 1'b1) break;
            hi++;
            if (hi > TBIT) begin
                dead = 1'b1;
                chk("fall_in_budget", 32'(data), 32'(0));
                return;
            end
        end
    endtask

    task automatic rx_frame(input int inj_bit);
        int lo, hi, prev_hi;
        bad_t   = 0;
        prev_hi = 0;
        for (int b = 0; b < BITS; b++) begin
            rx_bit(b == inj_bit, lo, hi);
            if (b == 0) first_lo = lo;
            else if (lo != TBIT - prev_hi - 1 + ((b % 24 == 0) ? 1 : 0)) bad_t++;
            if (hi == T1H) begin
                got[b / 24] = {got[b / 24][22:0], 1'b1};
            end else begin
                if (hi != T0H) bad_t++;
                got[b / 24] = {got[b / 24][22:0], 1'b0};
            end
            prev_hi = hi;
        end
        last_hi = prev_hi;
    endtask

    task automatic wait_idle(output int lo);
        lo = 0;
        if (dead) return;
        forever begin
            @(negedge clk);
            if (busy === 1'b0 || data !== 1'b0) break;
            lo++;
            if (lo > 2 * TRST) begin
                dead = 1'b1;
                chk("idle_in_budget", 32'(busy), 32'(0));
                return;
            end
        end
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_timing"}, 32'(bad_t), 32'(0));
        for (int i = 0; i < NB; i++)
            chk($sformatf("%s_led%0d", tag, i), 32'(got[i]), 32'(exp_f[i]));
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NB; i++) exp_f[i] = BLACK;
    endtask

    initial begin
        rst    = 1'b1;
        write  = 1'b0;
        color  = 24'h0;
        nb_led = 32'h0;

        chk("cyc_t0h", cyc_from_ns(100_000_000, 400), 32'd40);
        chk("cyc_t1h", cyc_from_ns(100_000_000, 800), 32'd80);
        chk("cyc_tbit", cyc_from_ns(100_000_000, 1250), 32'd125);
        chk("cyc_trst", cyc_from_us(100_000_000, 300), 32'd30000);

        // reset state, then latch gap and an all-black frame
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        rst = 1'b0;
        rx_frame(-1);
        chk("rst_gap", 32'(first_lo), 32'(TRST + 1));
        clear_exp();
        chk_frame("rst");
        wait_idle(lo_idle);
        chk("rst_tail", 32'(lo_idle), 32'(TBIT - last_hi - 1 + TRST));
        chk("idle_busy", 32'(busy), 32'(0));

        // single write while idle: first high on the third sample after the write
        pulse_write(32'd2, RED);
        rx_frame(-1);
        chk("wr_latency", 32'(first_lo), 32'(1));
        exp_f[2] = RED;
        chk_frame("red");
        wait_idle(lo_idle);
        chk("red_tail", 32'(lo_idle), 32'(TBIT - last_hi - 1 + TRST));

        // out-of-range indices start nothing
        pulse_write(32'd15, WHITE);
        pulse_write(32'hFFFF_FFFF, WHITE);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || data !== 1'b0) cnt++;
        end
        chk("oor_quiet", 32'(cnt), 32'(0));

        // held write: back-to-back frames, gap = bit tail + TRST + idle + load
        nb_led = 32'd2;
        color  = WHITE;
        write  = 1'b1;
        @(negedge clk);
        rx_frame(-1);
        chk("hold_latency", 32'(first_lo), 32'(1));
        exp_f[2] = WHITE;
        chk_frame("hold_a");
        write = 1'b0;
        rx_frame(-1);
        chk("hold_gap", 32'(first_lo), 32'(TBIT - T0H - 1 + TRST + 2));
        chk_frame("hold_b");
        wait_idle(lo_idle);
        chk("hold_tail", 32'(lo_idle), 32'(TBIT - last_hi - 1 + TRST));

        // write LED0 during its bit 10: lands only in the following frame
        pulse_write(32'd5, BLUE);
        rx_frame(10);
        chk("inj_latency", 32'(first_lo), 32'(1));
        exp_f[5] = BLUE;
        chk_frame("inj_a");
        rx_frame(-1);
        chk("inj_gap", 32'(first_lo), 32'(TBIT - T0H - 1 + TRST + 2));
        exp_f[0] = WHITE;
        chk_frame("inj_b");
        wait_idle(lo_idle);
        chk("inj_tail", 32'(lo_idle), 32'(TBIT - last_hi - 1 + TRST));

        // reset in the middle of LED7's first bit
        pulse_write(32'd7, GREEN);
        for (int b = 0; b < 7 * 24; b++) begin
            int lo, hi;
            rx_bit(1'b0, lo, hi);
        end
        cnt = 0;
        while (data !== 1'b1 && cnt <= 2 * TRST) begin
            @(negedge clk);
            cnt++;
        end
        chk("led7_rise", 32'(data), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", 32'(data), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(1));
        rst = 1'b0;
        rx_frame(-1);
        chk("midrst_gap", 32'(first_lo), 32'(TRST + 1));
        clear_exp();
        chk_frame("midrst");
        wait_idle(lo_idle);
        chk("midrst_tail", 32'(lo_idle), 32'(TBIT - last_hi - 1 + TRST));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
